// File: rtl/user_event_gen_pkg.sv
// Shared definitions for the player input front end: event codes,
// button indices and a counter-width helper.
package user_event_gen_pkg;

  // Event codes consumed by the game logic; 0 means "no event".
  localparam logic [2:0] EV_NONE     = 3'd0;
  localparam logic [2:0] EV_LEFT     = 3'd1;
  localparam logic [2:0] EV_RIGHT    = 3'd2;
  localparam logic [2:0] EV_DOWN     = 3'd3;
  localparam logic [2:0] EV_ROTATE   = 3'd4;
  localparam logic [2:0] EV_NEW_GAME = 3'd5;

  // Bit positions of each button inside the per-button vectors.
  localparam int NUM_BTN      = 5;
  localparam int IDX_LEFT     = 0;
  localparam int IDX_RIGHT    = 1;
  localparam int IDX_DOWN     = 2;
  localparam int IDX_ROTATE   = 3;
  localparam int IDX_NEW_GAME = 4;

  // Only the movement buttons auto-repeat.
  localparam logic [NUM_BTN-1:0] REPEAT_MASK = 5'b00111;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/user_event_gen_input_debounce.sv
// Two-flop synchronizer followed by a stability counter. The accepted
// level changes only after the synchronized input has differed from it
// for DEBOUNCE_CYCLES consecutive cycles; press_o pulses with a 0->1 change.
module input_debounce
  import user_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      stable_o <= 1'b0;
      press_o  <= 1'b0;
    end else begin
      press_o <= 1'b0;
      if (sync2 != stable_o) begin
        if (cnt == CNT_LAST) begin
          cnt      <= '0;
          stable_o <= sync2;
          press_o  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/user_event_gen.sv
// Player input front end: debounces five buttons, auto-repeats the
// movement buttons, coalesces triggers into pending flags and feeds a
// priority arbiter into a small show-ahead event queue.
module user_event_gen
  import user_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 250000,
  parameter int REPEAT_DELAY_CYCLES  = 12500000,
  parameter int REPEAT_PERIOD_CYCLES = 4000000,
  parameter int FIFO_DEPTH           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_down_i,
  input  logic       btn_rotate_i,
  input  logic       btn_new_game_i,
  output logic [2:0] user_event_o,
  output logic       user_event_ready_o,
  input  logic       user_event_rd_req_i
);

  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RW = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] RPT_DELAY_LOAD  = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LOAD = RW'(REPEAT_PERIOD_CYCLES - 1);
  localparam int PW = cnt_width(FIFO_DEPTH);
  localparam logic [PW:0] COUNT_FULL = (PW+1)'(FIFO_DEPTH);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] rpt_fire;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] grant;
  logic [RW-1:0]      rpt_cnt [NUM_BTN];

  logic [2:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               can_push;
  logic [2:0]         push_ev;

  assign raw = {btn_new_game_i, btn_rotate_i, btn_down_i, btn_right_i, btn_left_i};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw[g]),
      .stable_o(stable[g]),
      .press_o (press[g])
    );

    // Repeat down-counter: initial delay after a press, then the period; idle while released.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_cnt[g] <= '0;
      end else if (!stable[g]) begin
        rpt_cnt[g] <= '0;
      end else if (press[g]) begin
        rpt_cnt[g] <= RPT_DELAY_LOAD;
      end else if (rpt_cnt[g] == '0) begin
        rpt_cnt[g] <= RPT_PERIOD_LOAD;
      end else begin
        rpt_cnt[g] <= rpt_cnt[g] - 1'b1;
      end
    end

    // The press cycle itself also sees a zero count, so it must not fire.
    assign rpt_fire[g] = REPEAT_MASK[g] & stable[g] & ~press[g] & (rpt_cnt[g] == '0);
  end

  assign empty    = (count == '0);
  assign full     = (count == COUNT_FULL);
  assign pop      = user_event_rd_req_i & ~empty;
  assign can_push = ~full | pop;
  assign push     = |grant;

  // Fixed-priority pick of one pending event whenever the queue can take it.
  always_comb begin
    grant   = '0;
    push_ev = EV_NONE;
    if (can_push) begin
      if (pending[IDX_NEW_GAME]) begin
        grant[IDX_NEW_GAME] = 1'b1;
        push_ev             = EV_NEW_GAME;
      end else if (pending[IDX_ROTATE]) begin
        grant[IDX_ROTATE] = 1'b1;
        push_ev           = EV_ROTATE;
      end else if (pending[IDX_DOWN]) begin
        grant[IDX_DOWN] = 1'b1;
        push_ev         = EV_DOWN;
      end else if (pending[IDX_LEFT]) begin
        grant[IDX_LEFT] = 1'b1;
        push_ev         = EV_LEFT;
      end else if (pending[IDX_RIGHT]) begin
        grant[IDX_RIGHT] = 1'b1;
        push_ev          = EV_RIGHT;
      end
    end
  end

  // Pending flags: a new trigger wins over the grant that clears the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant) | press | rpt_fire;
    end
  end

  // Event queue storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= EV_NONE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign user_event_ready_o = ~empty;
  assign user_event_o       = empty ? EV_NONE : mem[rd_ptr];

endmodule

// File: tb/tb_user_event_gen.sv
// Scoreboard bench for user_event_gen with short debounce/repeat timing.
module tb_user_event_gen;
  import user_event_gen_pkg::*;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       left, right, down, rotate, new_game;
  logic       rd_req;
  logic [2:0] ev;
  logic       ready;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [2:0] exp_q [$];
  int         pop_cyc [$];
  logic [2:0] exp_ev;

  always #5 clk = ~clk;

  user_event_gen #(
    .DEBOUNCE_CYCLES     (DB),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_PERIOD_CYCLES(RP),
    .FIFO_DEPTH          (FD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .btn_left_i         (left),
    .btn_right_i        (right),
    .btn_down_i         (down),
    .btn_rotate_i       (rotate),
    .btn_new_game_i     (new_game),
    .user_event_o       (ev),
    .user_event_ready_o (ready),
    .user_event_rd_req_i(rd_req)
  );

  always @(posedge clk) cyc++;

  // Every accepted read is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && ready === 1'b1 && rd_req === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got ev=%0d at cyc %0d, expected nothing", ev, cyc);
      end else begin
        exp_ev = exp_q.pop_front();
        if (ev !== exp_ev) begin
          bad++;
          $display("FAIL pop_value: got ev=%0d, expected %0d at cyc %0d", ev, exp_ev, cyc);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit, output int seen);
    seen = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = cyc;
        break;
      end
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    pop_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_req = 1'b0;
    left = 0; right = 0; down = 0; rotate = 0; new_game = 0;
    step(3);
    @(negedge clk);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b, expected 0", ready); end
    total++;
    if (ev !== EV_NONE) begin bad++; $display("FAIL reset_event: got %0d, expected 0", ev); end
    step(1);
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_single_press();
    int t0, seen;
    clear_sb();
    step(1);
    rd_req = 1'b0;
    t0 = cyc;
    left = 1'b1;
    wait_ready(20, seen);
    total++;
    if (seen != t0 + 8) begin bad++; $display("FAIL single_latency: ready at cyc %0d, expected %0d", seen, t0 + 8); end
    total++;
    if (ev !== EV_LEFT) begin bad++; $display("FAIL single_event: got %0d, expected %0d", ev, EV_LEFT); end
    step(2);
    left = 1'b0;
    step(10);
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL single_held_entry: ready=%b, expected 1", ready); end
    exp_q.push_back(EV_LEFT);
    step(1);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL single_one_entry: ready=%b after one pop, expected 0", ready); end
    total++;
    if (pop_cyc.size() != 1) begin bad++; $display("FAIL single_pop_count: got %0d, expected 1", pop_cyc.size()); end
    // Glitch of 3 samples on right must be filtered.
    step(1);
    right = 1'b1;
    step(3);
    right = 1'b0;
    step(15);
    @(negedge clk);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL glitch_filtered: ready=%b ev=%0d, expected ready 0", ready, ev); end
  endtask

  task automatic test_simultaneous();
    int t0;
    clear_sb();
    step(1);
    rd_req = 1'b1;
    exp_q.push_back(EV_NEW_GAME);
    exp_q.push_back(EV_ROTATE);
    exp_q.push_back(EV_DOWN);
    t0 = cyc;
    rotate = 1'b1; down = 1'b1; new_game = 1'b1;
    step(10);
    rotate = 1'b0; down = 1'b0; new_game = 1'b0;
    step(12);
    @(negedge clk);
    total++;
    if (pop_cyc.size() != 3) begin
      bad++; $display("FAIL simul_count: got %0d events, expected 3", pop_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (pop_cyc[i] != t0 + 8 + i) begin
          bad++; $display("FAIL simul_timing: event %0d at cyc %0d, expected %0d", i, pop_cyc[i], t0 + 8 + i);
        end
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_auto_repeat();
    int offs[6];
    offs = '{0, 20, 28, 36, 44, 52};
    clear_sb();
    step(1);
    rd_req = 1'b1;
    repeat (6) exp_q.push_back(EV_DOWN);
    down = 1'b1;
    step(60);
    down = 1'b0;
    step(20);
    @(negedge clk);
    total++;
    if (pop_cyc.size() != 6) begin
      bad++; $display("FAIL repeat_count: got %0d events, expected 6", pop_cyc.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        total++;
        if (pop_cyc[i] - pop_cyc[0] != offs[i]) begin
          bad++; $display("FAIL repeat_timing: event %0d at +%0d, expected +%0d", i, pop_cyc[i] - pop_cyc[0], offs[i]);
        end
      end
    end
    clear_sb();
    exp_q.push_back(EV_ROTATE);
    rotate = 1'b1;
    step(60);
    rotate = 1'b0;
    step(20);
    @(negedge clk);
    total++;
    if (pop_cyc.size() != 1) begin bad++; $display("FAIL rotate_no_repeat: got %0d events, expected 1", pop_cyc.size()); end
    rd_req = 1'b0;
  endtask

  task automatic test_full_queue();
    clear_sb();
    step(1);
    rd_req = 1'b0;
    right = 1'b1;
    step(60);
    right = 1'b0;
    step(10);
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || ev !== EV_RIGHT) begin
      bad++; $display("FAIL full_ready: ready=%b ev=%0d, expected 1/%0d", ready, ev, EV_RIGHT);
    end
    repeat (FD + 1) exp_q.push_back(EV_RIGHT);
    step(1);
    rd_req = 1'b1;
    step(12);
    rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (pop_cyc.size() != FD + 1) begin bad++; $display("FAIL full_drain_count: got %0d events, expected %0d", pop_cyc.size(), FD + 1); end
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL full_drained: ready=%b, expected 0", ready); end
  endtask

  task automatic test_empty_pop_push_pop();
    int t1;
    clear_sb();
    step(1);
    rd_req = 1'b1;
    step(3);
    rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || ev !== EV_NONE || pop_cyc.size() != 0) begin
      bad++; $display("FAIL empty_pop: ready=%b ev=%0d pops=%0d, expected 0/0/0", ready, ev, pop_cyc.size());
    end
    step(1);
    left = 1'b1;
    step(6);
    left = 1'b0;
    t1 = cyc;
    right = 1'b1;
    exp_q.push_back(EV_LEFT);
    step(7);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    right = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || ev !== EV_RIGHT) begin
      bad++; $display("FAIL push_pop_head: ready=%b ev=%0d at cyc %0d (t1+%0d), expected 1/%0d", ready, ev, cyc, cyc - t1, EV_RIGHT);
    end
    total++;
    if (pop_cyc.size() != 1) begin bad++; $display("FAIL push_pop_count: got %0d pops, expected 1", pop_cyc.size()); end
    exp_q.push_back(EV_RIGHT);
    step(1);
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL push_pop_occupancy: ready=%b after one pop, expected 0", ready); end
    step(15);
  endtask

  task automatic test_reset_mid();
    int tr, seen;
    clear_sb();
    step(1);
    rd_req = 1'b0;
    rotate = 1'b1; new_game = 1'b1; left = 1'b1;
    step(12);
    rotate = 1'b0; new_game = 1'b0;
    step(3);
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL mid_before_reset: ready=%b, expected 1", ready); end
    rst = 1'b1;
    #1;
    total++;
    if (ready !== 1'b0 || ev !== EV_NONE) begin
      bad++; $display("FAIL mid_async_reset: ready=%b ev=%0d, expected 0/0", ready, ev);
    end
    exp_q.delete();
    step(3);
    rst = 1'b0;
    tr = cyc;
    exp_q.push_back(EV_LEFT);
    wait_ready(20, seen);
    total++;
    if (seen != tr + DB + 4) begin bad++; $display("FAIL mid_repress_latency: ready at cyc %0d, expected %0d", seen, tr + DB + 4); end
    step(1);
    rd_req = 1'b1;
    left = 1'b0;
    step(2);
    rd_req = 1'b0;
    @(negedge clk);
    total++;
    if (pop_cyc.size() != 1 || ready !== 1'b0) begin
      bad++; $display("FAIL mid_single_event: pops=%0d ready=%b, expected 1/0", pop_cyc.size(), ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_auto_repeat();
    test_full_queue();
    test_empty_pop_push_pop();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: %0d events never seen", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
